// File: rtl/key_scheduler_pkg.sv
// Shared definitions for the key scheduler: key code constants and the
// issue FSM state encoding.
package key_scheduler_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_HOLD = 2'd2
  } issue_state_t;

endpackage

// File: rtl/key_fifo.sv
// Synchronous key queue with flush.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   push/push_data write request and data (ignored when full unless flushing)
//   pop            remove head (ignored when empty)
//   flush          with push: discard all contents, push_data becomes sole entry
//   head           current head entry (valid when !empty)
//   count          occupancy 0..DEPTH
//   empty, full    occupancy flags
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // A flush restarts the queue at slot 0 holding only the flushing entry.
  // Any coincident pop has already consumed the head combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush && push) begin
      mem[0] <= push_data;
      rd_ptr <= '0;
      wr_ptr <= AW'(1);
      count  <= (AW+1)'(1);
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_scheduler.sv
// Key scheduler: round-robin accept of two key sources into a queue, and an
// issue FSM that strobes one key at a time to the compute datapath, with a
// forced idle holdoff after the equals key.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   k0_valid/k0_code/k0_ready  source 0 (matrix keypad) handshake
//   k1_valid/k1_code/k1_ready  source 1 (UART/remote) handshake
//   flag                       single-cycle key strobe
//   press_num                  key code, valid with flag, held otherwise
//   busy                       queue non-empty or FSM not idle
//   fifo_cnt                   queue occupancy
//
// state   | meaning
// IDLE    | waiting for a queued key; pops and strobes when one is present
// GAP     | strobe cycle of a normal key; one strobe-free cycle follows
// HOLD    | strobe cycle of equals plus holdoff countdown
module key_scheduler
  import key_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          k0_valid,
  input  logic [3:0]                    k0_code,
  output logic                          k0_ready,
  input  logic                          k1_valid,
  input  logic [3:0]                    k1_code,
  output logic                          k1_ready,
  output logic                          flag,
  output logic [3:0]                    press_num,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  logic         rr_ptr;
  logic         grant0, grant1;
  logic         accept, flush;
  logic [3:0]   acc_code;
  logic [3:0]   head;
  logic         fifo_empty, fifo_full;
  logic         pop;

  issue_state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic         flag_n;
  logic [3:0]   press_n;

  // A lone valid source wins regardless of the pointer.
  assign grant0 = k0_valid && (!k1_valid || !rr_ptr);
  assign grant1 = k1_valid && (!k0_valid ||  rr_ptr);

  // Clear is always accepted since it replaces the queue contents.
  // rst_n gating keeps the handshake quiet while in reset.
  assign k0_ready = rst_n && grant0 && (!fifo_full || k0_code == KEY_CLR);
  assign k1_ready = rst_n && grant1 && (!fifo_full || k1_code == KEY_CLR);

  assign accept   = k0_ready || k1_ready;
  assign acc_code = k1_ready ? k1_code : k0_code;
  assign flush    = accept && (acc_code == KEY_CLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~rr_ptr;
  end

  key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (acc_code),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      flag      <= 1'b0;
      press_num <= '0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_cnt_n;
      flag      <= flag_n;
      press_num <= press_n;
    end
  end

  // The GAP/HOLD state is entered on the same edge that raises flag, so the
  // strobe cycle itself is spent in GAP/HOLD and the idle cycles follow it.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    flag_n     = 1'b0;
    press_n    = press_num;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          flag_n  = 1'b1;
          press_n = head;
          if (head == KEY_EQ) begin
            state_n    = ST_HOLD;
            hold_cnt_n = HOLD_LOAD;
          end else begin
            state_n = ST_GAP;
          end
        end
      end
      ST_GAP: state_n = ST_IDLE;
      ST_HOLD: begin
        if (hold_cnt <= HW'(1)) begin
          state_n    = ST_IDLE;
          hold_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt - HW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_key_scheduler.sv
module tb_key_scheduler;
  import key_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       k0_valid = 1'b0, k1_valid = 1'b0;
  logic [3:0] k0_code = '0, k1_code = '0;
  logic       k0_ready, k1_ready, flag, busy;
  logic [3:0] press_num;
  logic [2:0] fifo_cnt;

  key_scheduler #(.FIFO_DEPTH(4), .HOLDOFF(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .k0_valid(k0_valid), .k0_code(k0_code), .k0_ready(k0_ready),
    .k1_valid(k1_valid), .k1_code(k1_code), .k1_ready(k1_ready),
    .flag(flag), .press_num(press_num), .busy(busy), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: expected strobes pushed at stimulus time, observed strobes
  // recorded by the monitor with their cycle stamps
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int         got_t[$];
  int         consec = 0;
  logic       prev_flag = 1'b0;
  int         n_cmp = 0, n_bad = 0;

  always @(negedge clk) begin
    if (flag) begin
      got_q.push_back(press_num);
      got_t.push_back(cyc);
    end
    if (flag && prev_flag) consec++;
    prev_flag = flag;
  end

  task automatic apply_reset();
    k0_valid = 0; k1_valid = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic send(input int src, input logic [3:0] code, output int acc);
    bit ok = 0;
    if (src == 0) begin k0_valid = 1; k0_code = code; end
    else begin k1_valid = 1; k1_code = code; end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (src == 0) ? k0_ready : k1_ready;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_timeout: src %0d code %0d ready never high", src, code);
    end
    @(posedge clk); #1;
    acc = cyc;
    k0_valid = 0; k1_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !busy && !flag;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_drain: busy still %0d after 200 cycles, required 0", name, busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; k0_valid = 1; k0_code = 4'd5;
    #1;
    n_cmp++; if (k0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_k0_ready: got %0b expected 0", k0_ready); end
    n_cmp++; if (flag !== 1'b0) begin n_bad++; $display("FAIL rst_flag: got %0b expected 0", flag); end
    n_cmp++; if (press_num !== 4'd0) begin n_bad++; $display("FAIL rst_press_num: got %0d expected 0", press_num); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_fifo_cnt: got %0d expected 0", fifo_cnt); end
    k0_valid = 0;
    apply_reset();
  endtask

  task automatic test_single();
    int acc;
    apply_reset();
    @(posedge clk); #1;
    exp_q.push_back(4'd7);
    send(0, 4'd7, acc);
    @(negedge clk);
    n_cmp++; if (fifo_cnt !== 3'd1) begin n_bad++; $display("FAIL single_cnt: got %0d expected 1", fifo_cnt); end
    @(negedge clk);
    n_cmp++; if (flag !== 1'b1 || press_num !== 4'd7) begin n_bad++; $display("FAIL single_strobe: got flag %0b num %0d expected 1/7", flag, press_num); end
    @(negedge clk);
    n_cmp++; if (flag !== 1'b0 || busy !== 1'b0 || press_num !== 4'd7) begin n_bad++; $display("FAIL single_after: got flag %0b busy %0b num %0d expected 0/0/7", flag, busy, press_num); end
    wait_idle("single");
    n_cmp++; if (got_q.size() != 1 || got_t.size() != 1 || got_t[0] != acc + 1) begin n_bad++; $display("FAIL single_latency: got %0d strobes, first at %0d expected 1 at %0d", got_q.size(), (got_t.size() > 0) ? got_t[0] : -1, acc + 1); end
  endtask

  task automatic test_contention();
    int n = 0;
    apply_reset();
    @(posedge clk); #1;
    k0_valid = 1; k0_code = 4'd1; k1_valid = 1; k1_code = 4'd2;
    for (int c = 0; c < 200 && n < 8; c++) begin
      @(negedge clk);
      n_cmp++; if (k0_ready && k1_ready) begin n_bad++; $display("FAIL cont_both_ready: got both ready expected at most one"); end
      if (k0_ready || k1_ready) begin
        n_cmp++;
        if ((k0_ready ? 4'd1 : 4'd2) !== ((n % 2 == 0) ? 4'd1 : 4'd2)) begin
          n_bad++; $display("FAIL cont_order: accept %0d got %0d expected %0d", n, k0_ready ? 1 : 2, (n % 2 == 0) ? 1 : 2);
        end
        exp_q.push_back((n % 2 == 0) ? 4'd1 : 4'd2);
        n++;
      end
    end
    @(posedge clk); #1;
    k0_valid = 0; k1_valid = 0;
    wait_idle("cont");
    for (int i = 1; i < got_t.size(); i++) begin
      n_cmp++; if (got_t[i] - got_t[i-1] != 2) begin n_bad++; $display("FAIL cont_spacing: strobe %0d got gap %0d expected 2", i, got_t[i] - got_t[i-1]); end
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL cont_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [3:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL cont_data: got %0d expected %0d", g, e); end
    end
  endtask

  task automatic test_holdoff();
    int acc;
    logic [3:0] seq [5] = '{4'd5, KEY_ADD, 4'd3, KEY_EQ, 4'd4};
    int gaps [4] = '{2, 2, 2, 4};
    apply_reset();
    @(posedge clk); #1;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i]);
      send(0, seq[i], acc);
    end
    wait_idle("hold");
    n_cmp++; if (got_t.size() != 5) begin n_bad++; $display("FAIL hold_count: got %0d strobes expected 5", got_t.size()); end
    for (int i = 1; i < got_t.size() && i < 5; i++) begin
      n_cmp++; if (got_t[i] - got_t[i-1] != gaps[i-1]) begin n_bad++; $display("FAIL hold_spacing: strobe %0d got gap %0d expected %0d", i, got_t[i] - got_t[i-1], gaps[i-1]); end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [3:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL hold_data: got %0d expected %0d", g, e); end
    end
  endtask

  task automatic test_full_clear();
    int acc;
    logic [3:0] seq [6] = '{4'd6, KEY_EQ, 4'd1, 4'd2, 4'd3, 4'd4};
    apply_reset();
    @(posedge clk); #1;
    foreach (seq[i]) send(0, seq[i], acc);
    exp_q.push_back(4'd6); exp_q.push_back(KEY_EQ); exp_q.push_back(KEY_CLR);
    @(negedge clk);
    n_cmp++; if (fifo_cnt !== 3'd4) begin n_bad++; $display("FAIL clr_full: got cnt %0d expected 4", fifo_cnt); end
    k1_valid = 1; k1_code = KEY_CLR;
    #1;
    n_cmp++; if (k1_ready !== 1'b1) begin n_bad++; $display("FAIL clr_ready: got %0b expected 1", k1_ready); end
    @(posedge clk); #1;
    k1_valid = 0;
    @(negedge clk);
    n_cmp++; if (fifo_cnt !== 3'd1) begin n_bad++; $display("FAIL clr_cnt: got %0d expected 1", fifo_cnt); end
    wait_idle("clr");
    n_cmp++; if (got_t.size() != 3 || got_t[2] - got_t[1] != 4) begin n_bad++; $display("FAIL clr_timing: got %0d strobes expected 3 with clear 4 cycles after equals", got_t.size()); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL clr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [3:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL clr_data: got %0d expected %0d", g, e); end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int waited = 0;
    bit ok = 0;
    logic [3:0] seq [5] = '{KEY_EQ, 4'd1, 4'd2, 4'd3, 4'd4};
    apply_reset();
    @(posedge clk); #1;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i]);
      send(0, seq[i], acc);
    end
    exp_q.push_back(4'd8);
    k0_valid = 1; k0_code = 4'd8;
    @(negedge clk);
    n_cmp++; if (k0_ready !== 1'b0 || fifo_cnt !== 3'd4) begin n_bad++; $display("FAIL bp_blocked: got ready %0b cnt %0d expected 0/4", k0_ready, fifo_cnt); end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      waited++;
      ok = k0_ready;
    end
    n_cmp++; if (!ok || waited != 1) begin n_bad++; $display("FAIL bp_release: ready after %0d cycles expected 1", waited); end
    @(posedge clk); #1;
    k0_valid = 0;
    wait_idle("bp");
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [3:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL bp_data: got %0d expected %0d", g, e); end
    end
  endtask

  task automatic test_reset_hold();
    int acc;
    logic [3:0] seq [4] = '{KEY_EQ, 4'd1, 4'd2, 4'd3};
    apply_reset();
    @(posedge clk); #1;
    foreach (seq[i]) send(0, seq[i], acc);
    @(negedge clk);
    n_cmp++; if (fifo_cnt !== 3'd3 || busy !== 1'b1) begin n_bad++; $display("FAIL rh_pre: got cnt %0d busy %0b expected 3/1", fifo_cnt, busy); end
    k0_valid = 1; k0_code = 4'd9;
    rst_n = 0;
    #1;
    n_cmp++; if (flag !== 0 || busy !== 0 || fifo_cnt !== 0 || k0_ready !== 0 || press_num !== 0) begin
      n_bad++; $display("FAIL rh_outputs: got flag %0b busy %0b cnt %0d ready %0b num %0d expected all 0", flag, busy, fifo_cnt, k0_ready, press_num);
    end
    @(negedge clk);
    k0_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    n_cmp++; if (got_q.size() != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL rh_no_strobe: got %0d strobes busy %0b expected 1/0", got_q.size(), busy); end
  endtask

  task automatic test_back_to_back();
    n_cmp++; if (consec != 0) begin n_bad++; $display("FAIL flag_consecutive: got %0d occurrences expected 0", consec); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_holdoff();
    test_full_clear();
    test_backpressure();
    test_reset_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, key-queue entries (power of two).
REQ-002 SHALL have parameter HOLDOFF, default 3, idle cycles forced after issuing code 15.
REQ-003 SHALL have one clock and asynchronous active-low reset; nothing else fixed beyond ports below.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 k0_valid  input  1  source 0 (matrix keypad) has a key code.
REQ-007 k0_code  input  4  source 0 key code (0-9 digit, 10-13 operator, 14 clear, 15 equals).
REQ-008 k0_ready  output  1  source 0 code accepted this cycle when high with k0_valid.
REQ-009 k1_valid / k1_code / k1_ready  input 1 / input 4 / output 1  same as source 0, for source 1 (UART/remote).
REQ-010 flag  output  1  single-cycle key strobe to compute datapath.
REQ-011 press_num  output  4  key code, valid while flag high, held otherwise.
REQ-012 busy  output  1  high when queue non-empty or issue FSM not IDLE.
REQ-013 fifo_cnt  output  3  current queue occupancy 0..FIFO_DEPTH.

Function
REQ-014 Accept side SHALL grant at most one source per cycle, round-robin; pointer toggles only on an accept.
REQ-015 Only one source valid: that source SHALL be granted regardless of pointer.
REQ-016 kX_ready SHALL be high only when source X granted, kX_valid high, and queue not full (or code is 14, REQ-021).
REQ-017 Accepted codes SHALL be written to the queue in accept order; all 16 codes pass unmodified.
REQ-018 Issue FSM states: IDLE, GAP, HOLD.
REQ-019 IDLE, queue non-empty: pop head, register flag=1 and press_num=head next edge; go GAP, or HOLD if head==15 with counter loaded HOLDOFF.
REQ-020 GAP: flag=0 one cycle, then IDLE. HOLD: flag=0, counter decrements each cycle, IDLE when counter reaches 0 (exactly HOLDOFF strobe-free cycles).
REQ-021 Accepted code 14 SHALL flush all queued entries and become the sole entry, accepted even when queue full.
REQ-022 Flush coincident with a pop: popped entry still issues; remaining entries discarded.
REQ-023 Code 14 arriving in HOLD/GAP SHALL wait for IDLE; no preemption of HOLD.
REQ-024 Latency: accept at edge E with queue empty and FSM IDLE -> flag high from E+1 to E+2.
REQ-025 Simultaneous push and pop SHALL leave fifo_cnt unchanged; full queue with pop frees slot next cycle, not same cycle.
REQ-026 flag SHALL never be high in two consecutive cycles.
REQ-027 Pointers and counter SHALL wrap modulo FIFO_DEPTH without loss.

Reset
REQ-028 On rst_n low: flag=0, press_num=0, busy=0, fifo_cnt=0, k0_ready=k1_ready=0, FSM IDLE, RR pointer favours source 0, holdoff counter 0.
REQ-029 Reset mid-HOLD or mid-queue SHALL discard all pending keys; no strobe after release until a new accept.

Structure
REQ-030 Shared package SHALL hold key code constants (KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_DIV=13, KEY_CLR=14, KEY_EQ=15) and FSM state encodings.
REQ-031 Queue SHALL be sub-module key_fifo (synchronous FIFO with push, pop, flush, count); arbiter and FSM in key_scheduler.

Verification
REQ-032 Single key: k0 sends 7 at edge 10 -> flag high cycle 11 only, press_num=7, busy low by cycle 13.
REQ-033 Contention: both valid continuously, k0=1, k1=2 -> accepts alternate 1,2,1,2; strobes spaced by one GAP cycle.
REQ-034 Equals holdoff: queue 5,10,3,15,4 -> strobes 5,10,3,15, then exactly 3 idle cycles, then 4.
REQ-035 Full/clear: fill 4 entries while FSM in HOLD; k1 sends 14 -> k1_ready high, fifo_cnt=1, next strobe after HOLD is 14.
REQ-036 Backpressure: queue full, k0_valid with 8 -> k0_ready low until a pop; 8 issued in order, none lost or duplicated.
REQ-037 Reset: assert rst_n low during HOLD with 3 queued -> all outputs 0 immediately; no strobe after release.
